// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM encoding, skid-buffer record and jal target helper
// for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int IWIDTH     = 32;
    localparam int DWIDTH     = 32;
    localparam int JUMP_WIDTH = 26;
    localparam int PC_WIDTH   = DWIDTH;

    localparam logic [IWIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_S_RST  = 2'd0,
        F_S_REQ  = 2'd1,
        F_S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IWIDTH-1:0]   instr;
        logic [PC_WIDTH-1:0] pc;
    } skid_t;

    // jal keeps the 256 MB region of the instruction after the jal
    function automatic logic [PC_WIDTH-1:0] jal_target(
        input logic [PC_WIDTH-1:0]   pc_plus4,
        input logic [JUMP_WIDTH-1:0] idx
    );
        return {pc_plus4[PC_WIDTH-1:PC_WIDTH-4], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus: master = fetch stage, slave = memory.
// Signals: f_o_imem_req/f_o_imem_addr out of fetch, f_i_imem_ack/rdata in.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                f_o_imem_req;
    logic [PC_WIDTH-1:0] f_o_imem_addr;
    logic                f_i_imem_ack;
    logic [IWIDTH-1:0]   f_i_imem_rdata;

    modport master (
        output f_o_imem_req,
        output f_o_imem_addr,
        input  f_i_imem_ack,
        input  f_i_imem_rdata
    );

    modport slave (
        input  f_o_imem_req,
        input  f_o_imem_addr,
        output f_i_imem_ack,
        output f_i_imem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Redirect priority mux: branch > jr > jal.
// Ports: redirect requests/targets in, redirect_o and target_o out.
module fetch_unit_pc_next_sel
    import fetch_unit_pkg::*;
(
    input  logic                  branch_taken_i,
    input  logic [PC_WIDTH-1:0]   branch_target_i,
    input  logic                  jr_i,
    input  logic [PC_WIDTH-1:0]   jr_addr_i,
    input  logic                  jal_i,
    input  logic [JUMP_WIDTH-1:0] jal_addr_i,
    input  logic [PC_WIDTH-1:0]   pc_plus4_i,
    output logic                  redirect_o,
    output logic [PC_WIDTH-1:0]   target_o
);

    assign redirect_o = branch_taken_i | jr_i | jal_i;

    // branch is the older instruction, so it wins over jr/jal
    always_comb begin
        target_o = jal_target(pc_plus4_i, jal_addr_i);
        priority case (1'b1)
            branch_taken_i: target_o = branch_target_i;
            jr_i:           target_o = jr_addr_i;
            default:        ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack, holds IF/ID + skid.
// Ports: clk/rst, stall/flush, redirects, imem bus, IF/ID outputs;
// FETCH_PERF_CNT_EN adds fetched/stall/redirect counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                  f_i_clk,
    input  logic                  f_i_rst,
    input  logic                  f_i_stall,
    input  logic                  f_i_flush,
    input  logic                  f_i_branch_taken,
    input  logic [PC_WIDTH-1:0]   f_i_branch_target,
    input  logic                  f_i_jr,
    input  logic [PC_WIDTH-1:0]   f_i_jr_addr,
    input  logic                  f_i_jal,
    input  logic [JUMP_WIDTH-1:0] f_i_jal_addr,
    fetch_unit_if.master          imem,
    output logic [IWIDTH-1:0]     f_o_instr,
    output logic                  f_o_ce,
    output logic [PC_WIDTH-1:0]   f_o_pc,
    output logic [PC_WIDTH-1:0]   f_o_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           f_o_cnt_fetched,
    output logic [31:0]           f_o_cnt_stall,
    output logic [31:0]           f_o_cnt_redirect
`endif
);

    fetch_state_e          state_q;
    logic                  req_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [IWIDTH-1:0]     instr_q;
    logic                  ce_q;
    logic [PC_WIDTH-1:0]   ifpc_q;
    logic [PC_WIDTH-1:0]   ifpc4_q;
    skid_t                 skid_q;

    logic                  redirect;
    logic [PC_WIDTH-1:0]   target_d;
    logic [PC_WIDTH-1:0]   seq_pc_d;
    logic [PC_WIDTH-1:0]   skid_pc4_d;

    assign seq_pc_d   = pc_q + PC_WIDTH'(4);
    assign skid_pc4_d = skid_q.pc + PC_WIDTH'(4);

    fetch_unit_pc_next_sel u_pc_next_sel (
        .branch_taken_i  (f_i_branch_taken),
        .branch_target_i (f_i_branch_target),
        .jr_i            (f_i_jr),
        .jr_addr_i       (f_i_jr_addr),
        .jal_i           (f_i_jal),
        .jal_addr_i      (f_i_jal_addr),
        .pc_plus4_i      (ifpc4_q),
        .redirect_o      (redirect),
        .target_o        (target_d)
    );

    always_ff @(posedge f_i_clk or posedge f_i_rst) begin
        if (f_i_rst) begin
            state_q <= F_S_RST;
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ce_q    <= 1'b0;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            skid_q  <= '0;
        end else if (redirect) begin
            // redirect drops any same-cycle ack and the skid entry
            pc_q    <= target_d;
            ce_q    <= 1'b0;
            skid_q  <= '0;
            state_q <= F_S_REQ;
            req_q   <= 1'b1;
        end else begin
            unique case (state_q)
                F_S_RST: begin
                    state_q <= F_S_REQ;
                    req_q   <= 1'b1;
                end
                F_S_REQ: begin
                    if (imem.f_i_imem_ack) begin
                        pc_q <= seq_pc_d;
                        if (f_i_flush) begin
                            ce_q <= 1'b0;
                        end else if (f_i_stall) begin
                            skid_q  <= '{instr: imem.f_i_imem_rdata,
                                         pc: pc_q};
                            state_q <= F_S_HOLD;
                            req_q   <= 1'b0;
                        end else begin
                            instr_q <= imem.f_i_imem_rdata;
                            ifpc_q  <= pc_q;
                            ifpc4_q <= seq_pc_d;
                            ce_q    <= 1'b1;
                        end
                    end else if (f_i_flush || !f_i_stall) begin
                        ce_q <= 1'b0;
                    end
                end
                F_S_HOLD: begin
                    if (f_i_flush) begin
                        ce_q    <= 1'b0;
                        skid_q  <= '0;
                        state_q <= F_S_REQ;
                        req_q   <= 1'b1;
                    end else if (!f_i_stall) begin
                        instr_q <= skid_q.instr;
                        ifpc_q  <= skid_q.pc;
                        ifpc4_q <= skid_pc4_d;
                        ce_q    <= 1'b1;
                        state_q <= F_S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= F_S_RST;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.f_o_imem_req  = req_q;
    assign imem.f_o_imem_addr = pc_q;
    assign f_o_instr          = instr_q;
    assign f_o_ce             = ce_q;
    assign f_o_pc             = ifpc_q;
    assign f_o_pc_plus4       = ifpc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic        load_fire;
    logic [31:0] cnt_fetched_q;
    logic [31:0] cnt_stall_q;
    logic [31:0] cnt_redirect_q;

    assign load_fire = !redirect && !f_i_flush && !f_i_stall &&
                       ((state_q == F_S_REQ && imem.f_i_imem_ack) ||
                        state_q == F_S_HOLD);

    always_ff @(posedge f_i_clk or posedge f_i_rst) begin
        if (f_i_rst) begin
            cnt_fetched_q  <= '0;
            cnt_stall_q    <= '0;
            cnt_redirect_q <= '0;
        end else begin
            if (load_fire) cnt_fetched_q <= cnt_fetched_q + 32'd1;
            if (f_i_stall) cnt_stall_q <= cnt_stall_q + 32'd1;
            if (redirect)  cnt_redirect_q <= cnt_redirect_q + 32'd1;
        end
    end

    assign f_o_cnt_fetched  = cnt_fetched_q;
    assign f_o_cnt_stall    = cnt_stall_q;
    assign f_o_cnt_redirect = cnt_redirect_q;
`endif

endmodule
